// File: rtl/led_pattern_shifter_if.sv
// Control and pattern signals of the LED pattern engine.
// The driver side (bench or lab top) uses master; the engine itself uses slave.
interface led_pattern_shifter_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       mode;
  logic             dir;
  logic             serial_in;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] q;
  logic             tick;
  logic             dir_o;
  logic             event_o;

  modport master (
    output mode, dir, serial_in, clear, load, load_data,
    input  q, tick, dir_o, event_o
  );

  modport slave (
    input  mode, dir, serial_in, clear, load, load_data,
    output q, tick, dir_o, event_o
  );
endinterface

// File: rtl/led_pattern_shifter.sv
// WIDTH-bit LED pattern register advanced once per prescaler wrap.
// Supports hold, serial shift-in, rotate and bounce, with clear and parallel load.
module led_pattern_shifter #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 23
) (
  input logic                  clk,
  input logic                  reset_n,
  led_pattern_shifter_if.slave bus
);
  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_ROTATE = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d;
  logic             event_q, event_d;
  logic             tick;
  logic             bounce_rev;
  logic             bounce_dir;
  mode_e            mode;

  assign mode = mode_e'(bus.mode);
  assign tick = (cnt_q == {DIV_W{1'b1}});

  // A lit bit at the wall we are heading toward reverses the bounce before shifting.
  assign bounce_rev = dir_q ? q_q[WIDTH-1] : q_q[0];
  assign bounce_dir = bounce_rev ? ~dir_q : dir_q;

  always_comb begin
    cnt_d   = cnt_q + CNT_ONE;
    q_d     = q_q;
    dir_d   = dir_q;
    event_d = 1'b0;
    if (bus.clear) begin
      cnt_d = '0;
      q_d   = '0;
    end else if (bus.load) begin
      q_d   = bus.load_data;
      dir_d = bus.dir;
    end else begin
      if (mode != MODE_BOUNCE) dir_d = bus.dir;
      if (tick) begin
        case (mode)
          MODE_SHIFT: begin
            q_d = bus.dir ? {q_q[WIDTH-2:0], bus.serial_in}
                          : {bus.serial_in, q_q[WIDTH-1:1]};
          end
          MODE_ROTATE: begin
            q_d     = bus.dir ? {q_q[WIDTH-2:0], q_q[WIDTH-1]}
                              : {q_q[0], q_q[WIDTH-1:1]};
            event_d = bus.dir ? q_q[WIDTH-1] : q_q[0];
          end
          MODE_BOUNCE: begin
            q_d     = bounce_dir ? {q_q[WIDTH-2:0], 1'b0}
                                 : {1'b0, q_q[WIDTH-1:1]};
            dir_d   = bounce_dir;
            event_d = bounce_rev;
          end
          default: q_d = q_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      q_q     <= '0;
      dir_q   <= 1'b0;
      event_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      dir_q   <= dir_d;
      event_q <= event_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.tick    = tick;
  assign bus.dir_o   = dir_q;
  assign bus.event_o = event_q;
endmodule

// File: tb/tb_led_pattern_shifter.sv
// Directed bench for led_pattern_shifter with WIDTH=4, DIV_W=2 (tick every 4 cycles).
module tb_led_pattern_shifter;
  localparam int WIDTH = 4;
  localparam int DIV_W = 2;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_fail;

  led_pattern_shifter_if #(.WIDTH(WIDTH)) bus ();

  led_pattern_shifter #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the edge, outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (bus.tick !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    n_cmp++;
    if (bus.tick !== 1'b1) begin
      $display("FAIL %s tick_timeout: tick=%b after %0d cycles, required 1", tag, bus.tick, n);
      n_fail++;
    end
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] data);
    bus.load      = 1'b1;
    bus.load_data = data;
    step();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_tick;
    reset_n = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (bus.q !== 4'b0000 || bus.dir_o !== 1'b0 || bus.event_o !== 1'b0 || bus.tick !== 1'b0) begin
      $display("FAIL reset_state: q=%b dir_o=%b event_o=%b tick=%b, required 0000 0 0 0",
               bus.q, bus.dir_o, bus.event_o, bus.tick);
      n_fail++;
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      exp_tick = (i == 3 || i == 7);
      n_cmp++;
      if (bus.tick !== exp_tick) begin
        $display("FAIL reset_tick_phase cycle %0d: tick=%b, required %b", i, bus.tick, exp_tick);
        n_fail++;
      end
    end
  endtask

  task automatic test_shift();
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] e;
    bus.mode      = 2'b01;
    bus.serial_in = 1'b1;
    for (int d = 0; d < 2; d++) begin
      bus.dir = d[0];
      do_clear();
      if (d == 0) exp_q = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
      else        exp_q = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        wait_tick("shift");
        step();
        n_cmp++;
        if (bus.q !== e || bus.event_o !== 1'b0) begin
          $display("FAIL shift dir=%0d: q=%b event_o=%b, required %b 0", d, bus.q, bus.event_o, e);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_rotate();
    logic [WIDTH-1:0] exp_q[$];
    logic             exp_ev[$];
    logic [WIDTH-1:0] e;
    logic             ev;
    bus.mode = 2'b10;
    bus.dir  = 1'b1;
    do_load(4'b0001);
    exp_q  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_ev = '{1'b0, 1'b0, 1'b0, 1'b1};
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ev = exp_ev.pop_front();
      wait_tick("rotate");
      step();
      n_cmp++;
      if (bus.q !== e || bus.event_o !== ev) begin
        $display("FAIL rotate_left: q=%b event_o=%b, required %b %b", bus.q, bus.event_o, e, ev);
        n_fail++;
      end
    end
    step();
    n_cmp++;
    if (bus.event_o !== 1'b0) begin
      $display("FAIL rotate_event_width: event_o=%b, required 0", bus.event_o);
      n_fail++;
    end
    bus.dir = 1'b0;
    wait_tick("rotate_right");
    step();
    n_cmp++;
    if (bus.q !== 4'b1000 || bus.event_o !== 1'b1 || bus.dir_o !== 1'b0) begin
      $display("FAIL rotate_right: q=%b event_o=%b dir_o=%b, required 1000 1 0",
               bus.q, bus.event_o, bus.dir_o);
      n_fail++;
    end
  endtask

  task automatic test_bounce();
    logic [WIDTH-1:0] exp_q[$];
    logic             exp_ev[$];
    logic             exp_dir[$];
    logic [WIDTH-1:0] e;
    logic             ev;
    logic             ed;
    bus.mode = 2'b11;
    bus.dir  = 1'b1;
    do_load(4'b0001);
    n_cmp++;
    if (bus.q !== 4'b0001 || bus.dir_o !== 1'b1) begin
      $display("FAIL bounce_load: q=%b dir_o=%b, required 0001 1", bus.q, bus.dir_o);
      n_fail++;
    end
    exp_q   = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    exp_ev  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_dir = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ev = exp_ev.pop_front();
      ed = exp_dir.pop_front();
      wait_tick("bounce");
      step();
      n_cmp++;
      if (bus.q !== e || bus.event_o !== ev || bus.dir_o !== ed) begin
        $display("FAIL bounce: q=%b event_o=%b dir_o=%b, required %b %b %b",
                 bus.q, bus.event_o, bus.dir_o, e, ev, ed);
        n_fail++;
      end
    end
  endtask

  task automatic test_priority();
    bus.mode = 2'b01;
    bus.dir  = 1'b0;
    bus.serial_in = 1'b1;
    do_load(4'b0110);
    wait_tick("prio_clear");
    bus.clear     = 1'b1;
    bus.load      = 1'b1;
    bus.load_data = 4'b1111;
    step();
    bus.clear = 1'b0;
    bus.load  = 1'b0;
    n_cmp++;
    if (bus.q !== 4'b0000 || bus.tick !== 1'b0) begin
      $display("FAIL prio_clear_load_tick: q=%b tick=%b, required 0000 0", bus.q, bus.tick);
      n_fail++;
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++;
      if (bus.tick !== (i == 3)) begin
        $display("FAIL prio_tick_restart cycle %0d: tick=%b, required %b", i, bus.tick, (i == 3));
        n_fail++;
      end
    end
    wait_tick("prio_load");
    do_load(4'b1010);
    n_cmp++;
    if (bus.q !== 4'b1010) begin
      $display("FAIL prio_load_eats_tick: q=%b, required 1010", bus.q);
      n_fail++;
    end
    wait_tick("prio_after_load");
    step();
    n_cmp++;
    if (bus.q !== 4'b1101) begin
      $display("FAIL prio_shift_after_load: q=%b, required 1101", bus.q);
      n_fail++;
    end
  endtask

  task automatic test_mid_run_reset();
    for (int v = 0; v < 2; v++) begin
      bus.mode = 2'b11;
      bus.dir  = 1'b1;
      do_load(4'b0010);
      wait_tick("midrun");
      step();
      n_cmp++;
      if (bus.q !== 4'b0100 || bus.dir_o !== 1'b1) begin
        $display("FAIL midrun_setup v%0d: q=%b dir_o=%b, required 0100 1", v, bus.q, bus.dir_o);
        n_fail++;
      end
      if (v == 0) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end else begin
        do_clear();
      end
      n_cmp++;
      if (bus.q !== 4'b0000 || bus.dir_o !== (v == 1) || bus.event_o !== 1'b0 || bus.tick !== 1'b0) begin
        $display("FAIL midrun_%s: q=%b dir_o=%b event_o=%b tick=%b, required 0000 %b 0 0",
                 (v == 0) ? "reset" : "clear", bus.q, bus.dir_o, bus.event_o, bus.tick, (v == 1));
        n_fail++;
      end
      for (int i = 1; i <= 3; i++) begin
        step();
        n_cmp++;
        if (bus.tick !== (i == 3) || bus.q !== 4'b0000) begin
          $display("FAIL midrun_restart v%0d cycle %0d: tick=%b q=%b, required %b 0000",
                   v, i, bus.tick, bus.q, (i == 3));
          n_fail++;
        end
      end
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_fail        = 0;
    reset_n       = 1'b0;
    bus.mode      = 2'b00;
    bus.dir       = 1'b0;
    bus.serial_in = 1'b0;
    bus.clear     = 1'b0;
    bus.load      = 1'b0;
    bus.load_data = '0;
    test_reset();
    test_shift();
    test_rotate();
    test_bounce();
    test_priority();
    test_mid_run_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
